// File: rtl/boot_sequencer.sv
// boot_sequencer: preloads data memory and streams boot packets into one core tile,
// then hands the data-memory port over to the core.
module boot_sequencer #(
    parameter int          DATA_WORDS  = 1024,
    parameter int          INSTR_WORDS = 1024,
    parameter int          REG_COUNT   = 64,
    parameter logic [31:0] START_PC    = 32'd0,
    parameter logic [31:0] BAR_MASK    = 32'h2,
    parameter logic [9:0]  BAR_ADDR    = 10'd24,
    parameter logic [9:0]  CORE_ID     = 10'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    output logic [1:0]  img_sel_o,
    output logic [11:0] img_addr_o,
    input  logic [39:0] img_data_i,
    output logic        mem_valid_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic        core_mem_valid_i,
    input  logic        core_mem_wen_i,
    input  logic [31:0] core_mem_addr_i,
    input  logic [31:0] core_mem_wdata_i,
    output logic        core_mem_ready_o,
    output logic        net_valid_o,
    output logic [2:0]  net_op_o,
    output logic [9:0]  net_id_o,
    output logic [9:0]  net_addr_o,
    output logic [31:0] net_data_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_INSTR = 3'd2;
    localparam logic [2:0] S_REG   = 3'd3;
    localparam logic [2:0] S_BAR   = 3'd4;
    localparam logic [2:0] S_PC    = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;
    localparam logic [2:0] OP_NULL  = 3'd0;
    localparam logic [2:0] OP_INSTR = 3'd1;
    localparam logic [2:0] OP_REG   = 3'd2;
    localparam logic [2:0] OP_BAR   = 3'd3;
    localparam logic [2:0] OP_PC    = 3'd4;
    localparam logic [12:0] DATA_LAST = 13'(DATA_WORDS - 1);
    localparam logic [12:0] INSTR_N   = 13'(INSTR_WORDS);
    localparam logic [12:0] REG_N     = 13'(REG_COUNT);

    logic [2:0]  state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic        first_q, first_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, done_q;
    logic [12:0] prev_idx;
    logic        run, writing, pkt_instr, pkt_reg, pkt_bar, pkt_pc;
    logic [31:0] boot_wdata;

    // Next-state: FSM, word/packet counter and the FETCH/WRITE phase of data loading
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        first_d = 1'b0;
        wdata_d = first_q ? img_data_i[31:0] : wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                end
            end
            S_DATA: begin
                if (DATA_WORDS == 0) begin
                    state_d = S_INSTR;
                end else if (!wr_q) begin
                    wr_d    = 1'b1;
                    first_d = 1'b1;
                end else if (mem_ready_i) begin
                    wr_d    = 1'b0;
                    cnt_d   = (cnt_q == DATA_LAST) ? '0 : cnt_q + 13'd1;
                    state_d = (cnt_q == DATA_LAST) ? S_INSTR : S_DATA;
                end
            end
            S_INSTR: begin
                cnt_d   = (cnt_q == INSTR_N) ? '0 : cnt_q + 13'd1;
                state_d = (cnt_q == INSTR_N) ? S_REG : S_INSTR;
            end
            S_REG: begin
                cnt_d   = (cnt_q == REG_N) ? '0 : cnt_q + 13'd1;
                state_d = (cnt_q == REG_N) ? S_BAR : S_REG;
            end
            S_BAR:   state_d = S_PC;
            S_PC:    state_d = S_RUN;
            default: state_d = state_q;
        endcase
    end

    // State registers; synchronous active-low reset abandons any boot in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            first_q <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            first_q <= first_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d != S_IDLE) && (state_d != S_RUN);
            done_q  <= (state_d == S_RUN);
        end
    end

    // Image data arrives in the first WRITE cycle; later stall cycles replay the captured copy
    assign boot_wdata = first_q ? img_data_i[31:0] : wdata_q;
    assign prev_idx   = cnt_q - 13'd1;
    assign run        = (state_q == S_RUN);
    assign writing    = (state_q == S_DATA) && wr_q;
    assign pkt_instr  = (state_q == S_INSTR) && (cnt_q != 13'd0);
    assign pkt_reg    = (state_q == S_REG) && (cnt_q != 13'd0);
    assign pkt_bar    = (state_q == S_BAR);
    assign pkt_pc     = (state_q == S_PC);

    assign img_sel_o  = (state_q == S_REG) ? 2'd2 : (state_q == S_INSTR) ? 2'd1 : 2'd0;
    assign img_addr_o = (state_q == S_DATA || state_q == S_INSTR || state_q == S_REG) ? cnt_q[11:0] : 12'd0;

    assign mem_valid_o      = run ? core_mem_valid_i : writing;
    assign mem_wen_o        = run ? core_mem_wen_i   : writing;
    assign mem_addr_o       = run ? core_mem_addr_i  : writing ? {17'd0, cnt_q, 2'b00} : 32'd0;
    assign mem_wdata_o      = run ? core_mem_wdata_i : writing ? boot_wdata : 32'd0;
    assign core_mem_ready_o = run & mem_ready_i;

    assign net_valid_o = pkt_instr | pkt_reg | pkt_bar | pkt_pc;
    assign net_op_o    = pkt_instr ? OP_INSTR : pkt_reg ? OP_REG : pkt_bar ? OP_BAR : pkt_pc ? OP_PC : OP_NULL;
    assign net_id_o    = net_valid_o ? CORE_ID : 10'd0;
    assign net_addr_o  = pkt_instr ? prev_idx[9:0] : pkt_reg ? {4'd0, img_data_i[37:32]} : pkt_bar ? BAR_ADDR : 10'd0;
    assign net_data_o  = pkt_instr ? {16'd0, img_data_i[15:0]} : pkt_reg ? img_data_i[31:0] :
                         pkt_bar ? BAR_MASK : pkt_pc ? START_PC : 32'd0;

    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: randomized boot runs checked against an image-derived write/packet model
module tb_boot_sequencer;
    localparam int N = 4;
    localparam int NPKT = 2 * N + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  img_sel_o;
    logic [11:0] img_addr_o;
    logic [39:0] img_data_i = '0;
    logic        mem_valid_o, mem_wen_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ready_i = 1'b1;
    logic        core_mem_valid_i = 1'b0, core_mem_wen_i = 1'b0;
    logic [31:0] core_mem_addr_i = '0, core_mem_wdata_i = '0;
    logic        core_mem_ready_o;
    logic        net_valid_o;
    logic [2:0]  net_op_o;
    logic [9:0]  net_id_o, net_addr_o;
    logic [31:0] net_data_o;
    logic        busy_o, done_o;

    boot_sequencer #(.DATA_WORDS(N), .INSTR_WORDS(N), .REG_COUNT(N)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .img_sel_o(img_sel_o), .img_addr_o(img_addr_o), .img_data_i(img_data_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .core_mem_valid_i(core_mem_valid_i), .core_mem_wen_i(core_mem_wen_i),
        .core_mem_addr_i(core_mem_addr_i), .core_mem_wdata_i(core_mem_wdata_i),
        .core_mem_ready_o(core_mem_ready_o),
        .net_valid_o(net_valid_o), .net_op_o(net_op_o), .net_id_o(net_id_o),
        .net_addr_o(net_addr_o), .net_data_o(net_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int gcyc = 0;
    int base = 0;
    int wi = 0, pi = 0, held4 = 0;
    int wcyc [N];
    logic        pend = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    logic [39:0] img [3*N];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected packet j of a boot: INSTR x N, REG x N, BAR, PC, taken straight from the image
    function automatic logic [63:0] exp_pkt(input int j);
        logic [39:0] w;
        if (j < N) begin
            w = img[N + j];
            return {9'd0, 3'd1, 10'd1, 10'(j), 16'd0, w[15:0]};
        end
        if (j < 2 * N) begin
            w = img[N + j];
            return {9'd0, 3'd2, 10'd1, 4'd0, w[37:32], w[31:0]};
        end
        if (j == 2 * N) return {9'd0, 3'd3, 10'd1, 10'd24, 32'h2};
        return {9'd0, 3'd4, 10'd1, 10'd0, 32'd0};
    endfunction

    always @(posedge clk) gcyc <= gcyc + 1;

    // Synchronous image ROM: word appears one cycle after the address
    always @(posedge clk) begin
        int idx;
        idx = int'(img_sel_o) * N + int'(img_addr_o);
        img_data_i <= (img_sel_o < 2'd3 && int'(img_addr_o) < N) ? img[idx] : 40'h0;
    end

    // Scoreboard monitor sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            pend = 1'b0;
        end else if (!done_o) begin
            check("core_rdy_boot", 128'(core_mem_ready_o), 128'(0));
            check("net_id_idle", 128'(net_valid_o ? 10'd0 : net_id_o), 128'(0));
            if (pend) check("stall_hold", {mem_valid_o, mem_addr_o, mem_wdata_o}, {1'b1, pa, pd});
            if (mem_valid_o && mem_addr_o == 32'd4) held4++;
            if (mem_valid_o && mem_ready_i) begin
                if (wi < N) begin
                    check("wr_addr", 128'(mem_addr_o), 128'(wi * 4));
                    check("wr_data", 128'(mem_wdata_o), 128'(img[wi][31:0]));
                    check("wr_wen", 128'(mem_wen_o), 128'(1));
                    wcyc[wi] = gcyc - base;
                end else check("wr_extra", 128'(wi), 128'(N - 1));
                wi++;
            end
            pend = mem_valid_o && !mem_ready_i;
            pa = mem_addr_o;
            pd = mem_wdata_o;
            if (net_valid_o) begin
                if (pi < NPKT) check("pkt", 128'({9'd0, net_op_o, net_id_o, net_addr_o, net_data_o}), 128'(exp_pkt(pi)));
                else check("pkt_extra", 128'(pi), 128'(NPKT - 1));
                pi++;
            end
        end else begin
            check("run_net", 128'({net_valid_o, net_op_o, net_id_o}), 128'(0));
            check("run_busy", 128'(busy_o), 128'(0));
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_mem"}, 128'({mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, core_mem_ready_o}), 128'(0));
        check({tag, "_net"}, 128'({img_sel_o, img_addr_o, net_valid_o, net_op_o, net_id_o, net_addr_o, net_data_o, busy_o, done_o}), 128'(0));
    endtask

    task automatic fill_image(input bit special);
        for (int i = 0; i < 3 * N; i++) img[i] = {8'($urandom), 32'($urandom)};
        if (special) begin
            img[2 * N] = 40'h05_DEADBEEF;
            img[N][15:0] = 16'hA5C3;
        end
    endtask

    task automatic start_pulse();
        @(posedge clk);
        #1 start_i = 1'b1;
        base = gcyc;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // mode 0: always ready; 1: word-1 stalled 3 cycles; 2: random ready, core noise, stray starts
    task automatic run_boot(input int mode, input bit special);
        int stl = 0;
        int t;
        fill_image(special);
        wi = 0; pi = 0; held4 = 0;
        mem_ready_i = 1'b1;
        start_pulse();
        for (t = 0; t < 400 && !done_o; t++) begin
            if (mode == 1) begin
                mem_ready_i = !(mem_valid_o && mem_addr_o == 32'd4 && stl < 3);
                if (!mem_ready_i) stl++;
            end else if (mode == 2) begin
                mem_ready_i = 1'($urandom_range(0, 1));
                core_mem_valid_i = 1'($urandom_range(0, 1));
                core_mem_wen_i = 1'($urandom_range(0, 1));
                core_mem_addr_i = $urandom;
                core_mem_wdata_i = $urandom;
                start_i = ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        core_mem_valid_i = 1'b0;
        check("done_reached", 128'(done_o), 128'(1));
        check("wr_count", 128'(wi), 128'(N));
        check("pkt_count", 128'(pi), 128'(NPKT));
        if (mode == 0) begin
            check("done_cycle", 128'(gcyc - base), 128'(21));
            for (int i = 0; i < N; i++) check("wr_cycle", 128'(wcyc[i]), 128'(2 + 2 * i));
        end
        if (mode == 1) check("held_addr4", 128'(held4), 128'(4));
    endtask

    task automatic run_phase();
        for (int k = 0; k < 4; k++) begin
            core_mem_valid_i = 1'b1;
            core_mem_wen_i = 1'($urandom_range(0, 1));
            core_mem_addr_i = (k == 0) ? 32'h100 : $urandom;
            core_mem_wdata_i = (k == 0) ? 32'h600DBEEF : $urandom;
            mem_ready_i = 1'($urandom_range(0, 1));
            start_i = 1'b1;
            @(negedge clk);
            check("run_mem", {mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o},
                  {1'b1, core_mem_wen_i, core_mem_addr_i, core_mem_wdata_i});
            check("run_rdy", 128'(core_mem_ready_o), 128'(mem_ready_i));
            check("run_done", 128'(done_o), 128'(1));
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        core_mem_valid_i = 1'b0;
        mem_ready_i = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        run_boot(0, 1'b1);
        run_phase();
        begin
            int t;
            reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            run_boot(1, 1'b0);
            reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            fill_image(1'b0);
            wi = 0; pi = 0;
            start_pulse();
            for (t = 0; t < 100 && net_op_o != 3'd1; t++) begin
                @(posedge clk);
                #1;
            end
            check("reach_instr", 128'(net_op_o), 128'(1));
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_zero("mid_reset");
            @(posedge clk);
            #1 reset = 1'b1;
        end
        run_boot(0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            reset = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            run_boot(2, 1'b0);
            run_phase();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
